// File: rtl/pipeline_regfile.sv
// rtl/pipeline_regfile.sv - architectural register file with per-register RAW hazard scoreboard
//
// Purpose: x1..x31 storage written by writeback, two combinational read ports
// for decode, and a saturating pending-write counter per register. Decode is
// stalled while a source register has outstanding writes, and an issue is
// refused when its destination counter is already at its maximum.
//
// Optional feature macro: PIPELINE_REGFILE_BYPASS_EN
//   defined   - same-cycle writeback data is forwarded to the read ports and
//               counts as retiring one pending write for hazard purposes.
//   undefined - reads see the array only; the written value appears next cycle.
//
// Ports:
//   clk_i        - clock, rising edge
//   reset_i      - synchronous reset, active low
//   rs1_i/rs2_i  - read indices from decode
//   rs1_data_o/rs2_data_o - combinational read data
//   issue_i, issue_rd_i   - decode issuing an instruction that writes issue_rd_i
//   wb_we_i, wb_rd_i, wb_data_i - writeback write port
//   stall_o      - RAW hazard on rs1 or rs2
//   issue_ack_o  - issue accepted this cycle
//   err_o        - sticky counter overflow/underflow flag

module pipeline_regfile #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_i,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_i,
    output logic [31:0]                 rs1_data_o,
    output logic [31:0]                 rs2_data_o,
    input  logic                        issue_i,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd_i,
    input  logic                        wb_we_i,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd_i,
    input  logic [31:0]                 wb_data_i,
    output logic                        stall_o,
    output logic                        issue_ack_o,
    output logic                        err_o
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      regs [1:NUM_REGS-1];
    logic [CNT_W-1:0] cnt  [1:NUM_REGS-1];

    // Writes to x0 are dropped entirely, including their effect on counters.
    logic wb_write;
    assign wb_write = wb_we_i && (wb_rd_i != '0);

    // x0 has no storage; every lookup is guarded so index 0 never reaches the arrays.
    logic [31:0]      rs1_arr, rs2_arr;
    logic [CNT_W-1:0] rs1_cnt, rs2_cnt, issue_cnt;

    always_comb begin
        rs1_arr   = '0;
        rs2_arr   = '0;
        rs1_cnt   = '0;
        rs2_cnt   = '0;
        issue_cnt = '0;
        if (rs1_i != '0) begin
            rs1_arr = regs[rs1_i];
            rs1_cnt = cnt[rs1_i];
        end
        if (rs2_i != '0) begin
            rs2_arr = regs[rs2_i];
            rs2_cnt = cnt[rs2_i];
        end
        if (issue_rd_i != '0) begin
            issue_cnt = cnt[issue_rd_i];
        end
    end

    logic rs1_busy, rs2_busy;

`ifdef PIPELINE_REGFILE_BYPASS_EN
    logic wb_hit_rs1, wb_hit_rs2;
    assign wb_hit_rs1 = wb_write && (wb_rd_i == rs1_i);
    assign wb_hit_rs2 = wb_write && (wb_rd_i == rs2_i);

    assign rs1_data_o = wb_hit_rs1 ? wb_data_i : rs1_arr;
    assign rs2_data_o = wb_hit_rs2 ? wb_data_i : rs2_arr;

    // A writeback this cycle retires one pending write, so the register is
    // still busy only if more than one write was outstanding.
    assign rs1_busy = wb_hit_rs1 ? (rs1_cnt > 1) : (rs1_cnt != '0);
    assign rs2_busy = wb_hit_rs2 ? (rs2_cnt > 1) : (rs2_cnt != '0);
`else
    assign rs1_data_o = rs1_arr;
    assign rs2_data_o = rs2_arr;

    assign rs1_busy = (rs1_cnt != '0);
    assign rs2_busy = (rs2_cnt != '0);
`endif

    // rs*_cnt are forced to zero for x0, so x0 is never busy.
    assign stall_o = rs1_busy || rs2_busy;

    // A same-cycle writeback to the destination frees a slot, so the issue fits.
    logic full;
    assign full = (issue_rd_i != '0) && (issue_cnt == CNT_MAX) &&
                  !(wb_write && (wb_rd_i == issue_rd_i));

    // Reset dominates, so nothing is acknowledged while it is held.
    logic issue_accept;
    assign issue_accept = issue_i && !stall_o && !full && reset_i;
    assign issue_ack_o  = issue_accept;

    logic [NUM_REGS-1:1] inc_vec, dec_vec;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_vec[r] = issue_accept && (issue_rd_i == IDX_W'(r));
            dec_vec[r] = wb_write && (wb_rd_i == IDX_W'(r));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err_o <= 1'b0;
        end else begin
            if (wb_write) begin
                regs[wb_rd_i] <= wb_data_i;
            end
            // Issue and writeback to the same register cancel out; otherwise
            // the counter saturates and the event is flagged as an error.
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    if (cnt[r] == CNT_MAX) begin
                        err_o <= 1'b1;
                    end else begin
                        cnt[r] <= cnt[r] + 1'b1;
                    end
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    if (cnt[r] == '0) begin
                        err_o <= 1'b1;
                    end else begin
                        cnt[r] <= cnt[r] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_regfile.sv
// tb/tb_pipeline_regfile.sv - directed self-checking bench for pipeline_regfile

module tb_pipeline_regfile;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [4:0]  rs1_i, rs2_i;
    logic [31:0] rs1_data_o, rs2_data_o;
    logic        issue_i;
    logic [4:0]  issue_rd_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        stall_o, issue_ack_o, err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pipeline_regfile #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rs1_data_o  (rs1_data_o),
        .rs2_data_o  (rs2_data_o),
        .issue_i     (issue_i),
        .issue_rd_i  (issue_rd_i),
        .wb_we_i     (wb_we_i),
        .wb_rd_i     (wb_rd_i),
        .wb_data_i   (wb_data_i),
        .stall_o     (stall_o),
        .issue_ack_o (issue_ack_o),
        .err_o       (err_o)
    );

`ifdef PIPELINE_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic idle();
        reset_i    = 1'b1;
        rs1_i      = '0;
        rs2_i      = '0;
        issue_i    = 1'b0;
        issue_rd_i = '0;
        wb_we_i    = 1'b0;
        wb_rd_i    = '0;
        wb_data_i  = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        idle();
        reset_i = 1'b0;
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_reset();
        pulse_reset();
        #1;
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
        checks++;
        if (issue_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", issue_ack_o); end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_i);
            rs1_i = 5'(i);
            rs2_i = 5'(31 - i);
            #1;
            checks++;
            if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0 || stall_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_read x%0d: got rs1=%h rs2=%h stall=%b expected 0 0 0",
                         i, rs1_data_o, rs2_data_o, stall_o);
            end
        end
    endtask

    task automatic test_x0();
        @(negedge clk_i);
        idle();
        wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (rs1_data_o !== 32'h0) begin errors++; $display("FAIL x0_same_cycle: got %h expected 0", rs1_data_o); end
        @(negedge clk_i);
        idle();
        #1;
        checks++;
        if (rs1_data_o !== 32'h0) begin errors++; $display("FAIL x0_after_write: got %h expected 0", rs1_data_o); end
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL x0_no_err: got %b expected 0", err_o); end
    endtask

    task automatic test_write_read();
        @(negedge clk_i);
        idle();
        wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h12345678;
        rs1_i = 5'd5; rs2_i = 5'd5;
        #1;
        checks++;
        if (rs1_data_o !== (BYP ? 32'h12345678 : 32'h0) || rs2_data_o !== rs1_data_o) begin
            errors++;
            $display("FAIL write_same_cycle: got rs1=%h rs2=%h expected %h",
                     rs1_data_o, rs2_data_o, BYP ? 32'h12345678 : 32'h0);
        end
        @(negedge clk_i);
        idle();
        rs1_i = 5'd5; rs2_i = 5'd5;
        #1;
        checks++;
        if (rs1_data_o !== 32'h12345678 || rs2_data_o !== 32'h12345678) begin
            errors++;
            $display("FAIL write_next_cycle: got rs1=%h rs2=%h expected 12345678", rs1_data_o, rs2_data_o);
        end
    endtask

    task automatic test_raw_stall();
        @(negedge clk_i);
        idle();
        issue_i = 1'b1; issue_rd_i = 5'd7;
        #1;
        checks++;
        if (issue_ack_o !== 1'b1) begin errors++; $display("FAIL raw_issue_ack: got %b expected 1", issue_ack_o); end
        @(negedge clk_i);
        idle();
        rs1_i = 5'd7;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL raw_stall_rs1: got %b expected 1", stall_o); end
        @(negedge clk_i);
        rs1_i = 5'd0; rs2_i = 5'd7;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL raw_stall_rs2: got %b expected 1", stall_o); end
        @(negedge clk_i);
        rs1_i = 5'd7; rs2_i = 5'd7;
        wb_we_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'hCAFEF00D;
        #1;
        checks++;
        if (stall_o !== !BYP) begin errors++; $display("FAIL raw_wb_cycle_stall: got %b expected %b", stall_o, !BYP); end
        checks++;
        if (rs1_data_o !== (BYP ? 32'hCAFEF00D : 32'h0) || rs2_data_o !== rs1_data_o) begin
            errors++;
            $display("FAIL raw_wb_cycle_data: got rs1=%h rs2=%h expected %h",
                     rs1_data_o, rs2_data_o, BYP ? 32'hCAFEF00D : 32'h0);
        end
        @(negedge clk_i);
        idle();
        rs1_i = 5'd7; rs2_i = 5'd7;
        #1;
        checks++;
        if (stall_o !== 1'b0 || rs1_data_o !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL raw_after_wb: got stall=%b data=%h expected 0 cafef00d", stall_o, rs1_data_o);
        end
        // Self-dependence: add x5,x5,x1 must not stall on its own issue.
        @(negedge clk_i);
        idle();
        rs1_i = 5'd5; rs2_i = 5'd1; issue_i = 1'b1; issue_rd_i = 5'd5;
        #1;
        checks++;
        if (stall_o !== 1'b0 || issue_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL self_dep: got stall=%b ack=%b expected 0 1", stall_o, issue_ack_o);
        end
        @(negedge clk_i);
        idle();
        rs1_i = 5'd5;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL self_dep_pending: got %b expected 1", stall_o); end
        @(negedge clk_i);
        idle();
        wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h55;
        @(negedge clk_i);
        idle();
        rs1_i = 5'd5;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL self_dep_retired: got %b expected 0", stall_o); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            idle();
            issue_i = 1'b1; issue_rd_i = 5'd9;
            #1;
            checks++;
            if (issue_ack_o !== 1'b1) begin errors++; $display("FAIL full_issue%0d_ack: got %b expected 1", k, issue_ack_o); end
        end
        @(negedge clk_i);
        idle();
        issue_i = 1'b1; issue_rd_i = 5'd9;
        #1;
        checks++;
        if (issue_ack_o !== 1'b0) begin errors++; $display("FAIL full_fourth_ack: got %b expected 0", issue_ack_o); end
        @(negedge clk_i);
        idle();
        issue_i = 1'b1; issue_rd_i = 5'd9;
        wb_we_i = 1'b1; wb_rd_i = 5'd9; wb_data_i = 32'h99;
        #1;
        checks++;
        if (issue_ack_o !== 1'b1) begin errors++; $display("FAIL full_concurrent_ack: got %b expected 1", issue_ack_o); end
        // Counter must still be 3: three writebacks needed to clear the hazard.
        @(negedge clk_i);
        idle();
        rs1_i = 5'd9;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL full_pending: got %b expected 1", stall_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            idle();
            rs1_i = 5'd9;
            wb_we_i = 1'b1; wb_rd_i = 5'd9; wb_data_i = 32'h900 + 32'(k);
            #1;
            checks++;
            if (stall_o !== ((k < 2) ? 1'b1 : !BYP)) begin
                errors++;
                $display("FAIL full_drain%0d_stall: got %b expected %b", k, stall_o, (k < 2) ? 1'b1 : !BYP);
            end
        end
        @(negedge clk_i);
        idle();
        rs1_i = 5'd9;
        #1;
        checks++;
        if (stall_o !== 1'b0 || rs1_data_o !== 32'h902) begin
            errors++;
            $display("FAIL full_drained: got stall=%b data=%h expected 0 00000902", stall_o, rs1_data_o);
        end
    endtask

    task automatic test_err();
        pulse_reset();
        #1;
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL err_cleared_before: got %b expected 0", err_o); end
        @(negedge clk_i);
        idle();
        wb_we_i = 1'b1; wb_rd_i = 5'd4; wb_data_i = 32'h44444444;
        @(negedge clk_i);
        idle();
        rs1_i = 5'd4;
        #1;
        checks++;
        if (err_o !== 1'b1 || rs1_data_o !== 32'h44444444) begin
            errors++;
            $display("FAIL err_underflow: got err=%b data=%h expected 1 44444444", err_o, rs1_data_o);
        end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL err_cnt_stays0: got stall=%b expected 0", stall_o); end
        @(negedge clk_i);
        #1;
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_o); end
        pulse_reset();
        rs1_i = 5'd4;
        #1;
        checks++;
        if (err_o !== 1'b0 || rs1_data_o !== 32'h0) begin
            errors++;
            $display("FAIL err_reset: got err=%b x4=%h expected 0 0", err_o, rs1_data_o);
        end
    endtask

    task automatic test_reset_dominates();
        @(negedge clk_i);
        idle();
        reset_i = 1'b0;
        issue_i = 1'b1; issue_rd_i = 5'd3;
        wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'h1;
        @(negedge clk_i);
        idle();
        rs1_i = 5'd3; rs2_i = 5'd3;
        #1;
        checks++;
        if (rs1_data_o !== 32'h0 || stall_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_dominates: got x3=%h stall=%b err=%b expected 0 0 0",
                     rs1_data_o, stall_o, err_o);
        end
        // A counter left at zero means a fresh writeback to x3 underflows.
        @(negedge clk_i);
        idle();
        issue_i = 1'b1; issue_rd_i = 5'd3;
        @(negedge clk_i);
        idle();
        rs1_i = 5'd3;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL reset_dominates_cnt1: got %b expected 1", stall_o); end
        @(negedge clk_i);
        idle();
        wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'h3;
        @(negedge clk_i);
        idle();
        rs1_i = 5'd3;
        #1;
        checks++;
        if (stall_o !== 1'b0 || err_o !== 1'b0 || rs1_data_o !== 32'h3) begin
            errors++;
            $display("FAIL reset_dominates_cnt0: got stall=%b err=%b x3=%h expected 0 0 3",
                     stall_o, err_o, rs1_data_o);
        end
    endtask

    initial begin
        idle();
        reset_i = 1'b0;
        test_reset();
        test_x0();
        test_write_read();
        test_raw_stall();
        test_full();
        test_err();
        test_reset_dominates();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
